// File: rtl/line_buffer_if.sv
// Pixel stream interface for line_buffer.
// The master drives the input pixel strobe. The slave returns the previous-row pixel and its coordinates.
interface line_buffer_if #(
    parameter int N      = 8,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    logic          ce;
    logic          sof;
    logic [N-1:0]  idata;
    logic [N-1:0]  odata;
    logic          ovalid;
    logic [CW-1:0] ocol;
    logic [RW-1:0] orow;
    logic          eol;

    modport master (
        output ce, sof, idata,
        input  odata, ovalid, ocol, orow, eol
    );

    modport slave (
        input  ce, sof, idata,
        output odata, ovalid, ocol, orow, eol
    );
endinterface

// File: rtl/line_buffer.sv
// One-row delay for the pixel stream. For each accepted pixel it returns the pixel
// from the same column one row earlier, together with that pixel's column/row position.
module line_buffer #(
    parameter int N      = 8,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic         clk,
    input  logic         rst_n,
    line_buffer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

    logic [N-1:0]  ram [WIDTH];

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] ocol_q, ocol_d;
    logic [RW-1:0] orow_q, orow_d;
    logic          ovalid_q, ovalid_d;
    logic          eol_q, eol_d;
    logic          rd_valid_q, rd_valid_d;
    logic [N-1:0]  rd_q, rd_d;

    logic          start;
    logic [CW-1:0] ecol;
    logic [RW-1:0] erow;
    logic          last_col;
    logic          last_row;

    always_comb begin
        start    = bus.ce & bus.sof;
        ecol     = start ? '0 : col_q;
        erow     = start ? '0 : row_q;
        last_col = (ecol == LAST_COL);
        last_row = (erow == LAST_ROW);

        col_d = col_q;
        row_d = row_q;
        if (bus.ce) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : erow + RW'(1);
            end else begin
                col_d = ecol + CW'(1);
                row_d = erow;
            end
        end

        ovalid_d   = bus.ce & (erow != '0);
        eol_d      = bus.ce & last_col;
        ocol_d     = bus.ce ? ecol : ocol_q;
        orow_d     = bus.ce ? erow : orow_q;
        rd_valid_d = rd_valid_q | bus.ce;
        rd_d       = ram[ecol];
    end

    // The array and its read register have no reset so that they map onto block RAM.
    // The old contents are read before the new pixel is written.
    always_ff @(posedge clk) begin
        if (bus.ce) begin
            rd_q      <= rd_d;
            ram[ecol] <= bus.idata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            ocol_q     <= '0;
            orow_q     <= '0;
            ovalid_q   <= 1'b0;
            eol_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            ocol_q     <= ocol_d;
            orow_q     <= orow_d;
            ovalid_q   <= ovalid_d;
            eol_q      <= eol_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // odata is forced to zero from reset until the first read, because the read register itself is not reset.
    assign bus.odata  = rd_valid_q ? rd_q : '0;
    assign bus.ovalid = ovalid_q;
    assign bus.ocol   = ocol_q;
    assign bus.orow   = orow_q;
    assign bus.eol    = eol_q;
endmodule

// File: tb/tb_line_buffer.sv
// Self-checking bench for line_buffer (N=8, WIDTH=4, HEIGHT=3) using a queue scoreboard.
module tb_line_buffer;
    localparam int N      = 8;
    localparam int WIDTH  = 4;
    localparam int HEIGHT = 3;

    typedef struct {
        logic [N-1:0] odata;
        bit           ovalid;
        int           ocol;
        int           orow;
        bit           eol;
    } exp_t;

    logic clk;
    logic rst_n;

    line_buffer_if #(.N(N), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) bus ();

    line_buffer #(.N(N), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total;
    int bad;

    exp_t         sb[$];
    logic [N-1:0] m_ram [WIDTH];
    int           m_col;
    int           m_row;
    logic [N-1:0] hold_odata;
    bit           hold_known;
    int           hold_col;
    int           hold_row;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        m_col      = 0;
        m_row      = 0;
        hold_odata = '0;
        hold_known = 1'b1;
        hold_col   = 0;
        hold_row   = 0;
        sb.delete();
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, "_odata"},  int'(bus.odata),  0);
        checkOutput({tag, "_ovalid"}, int'(bus.ovalid), 0);
        checkOutput({tag, "_ocol"},   int'(bus.ocol),   0);
        checkOutput({tag, "_orow"},   int'(bus.orow),   0);
        checkOutput({tag, "_eol"},    int'(bus.eol),    0);
    endtask

    // Drives one cycle. Accepted pixels are modelled and pushed to the scoreboard, then popped and compared after the edge.
    task automatic applyStimulus(input bit ce_in, input bit sof_in, input logic [N-1:0] data_in);
        exp_t e;
        int   ecol;
        int   erow;
        bus.ce    = ce_in;
        bus.sof   = sof_in;
        bus.idata = data_in;
        if (ce_in) begin
            ecol     = sof_in ? 0 : m_col;
            erow     = sof_in ? 0 : m_row;
            e.odata  = m_ram[ecol];
            e.ovalid = (erow != 0);
            e.ocol   = ecol;
            e.orow   = erow;
            e.eol    = (ecol == WIDTH - 1);
            m_ram[ecol] = data_in;
            if (ecol == WIDTH - 1) begin
                m_col = 0;
                m_row = (erow == HEIGHT - 1) ? 0 : erow + 1;
            end else begin
                m_col = ecol + 1;
                m_row = erow;
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (ce_in) begin
            if (sb.size() == 0) begin
                checkOutput("sb_empty", 0, 1);
            end else begin
                e = sb.pop_front();
                checkOutput("ovalid", int'(bus.ovalid), int'(e.ovalid));
                checkOutput("ocol",   int'(bus.ocol),   e.ocol);
                checkOutput("orow",   int'(bus.orow),   e.orow);
                checkOutput("eol",    int'(bus.eol),    int'(e.eol));
                if (e.ovalid) checkOutput("odata", int'(bus.odata), int'(e.odata));
                hold_known = e.ovalid;
                hold_odata = e.odata;
                hold_col   = e.ocol;
                hold_row   = e.orow;
            end
        end else begin
            checkOutput("idle_ovalid", int'(bus.ovalid), 0);
            checkOutput("idle_eol",    int'(bus.eol),    0);
            checkOutput("idle_ocol",   int'(bus.ocol),   hold_col);
            checkOutput("idle_orow",   int'(bus.orow),   hold_row);
            if (hold_known) checkOutput("idle_odata", int'(bus.odata), int'(hold_odata));
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        bus.ce    = 1'b0;
        bus.sof   = 1'b0;
        bus.idata = '0;
        for (int i = 0; i < WIDTH; i++) m_ram[i] = '0;
        resetModel();
        #1;

        // Test 1: reset held while the inputs are active
        for (int i = 0; i < 6; i++) begin
            bus.ce    = 1'($urandom_range(0, 1));
            bus.sof   = 1'($urandom_range(0, 1));
            bus.idata = N'($urandom);
            @(posedge clk);
            #1;
            checkZero("rst");
        end
        bus.ce  = 1'b0;
        bus.sof = 1'b0;
        rst_n   = 1'b1;
        resetModel();

        // Test 2: continuous stream of 0..11
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, i == 0, N'(i));

        // Test 3: same stream with a strobe every third cycle; sof on an idle cycle must be ignored
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, i == 0, N'(i));
            applyStimulus(1'b0, 1'b1, N'($urandom));
            applyStimulus(1'b0, 1'b0, N'($urandom));
        end

        // Test 4: sof arrives at row 1, col 2
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, i == 0, N'($urandom));
        applyStimulus(1'b1, 1'b1, N'($urandom));
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, N'($urandom));

        // Test 5: wrap at HEIGHT-1 without sof
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, i == 0, N'($urandom));
        applyStimulus(1'b1, 1'b0, N'($urandom));
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, N'($urandom));

        // Test 6: asynchronous reset pulse between edges, mid-frame
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, i == 0, N'($urandom));
        bus.ce = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkZero("async_rst");
        #1;
        rst_n = 1'b1;
        resetModel();
        applyStimulus(1'b1, 1'b0, N'($urandom));
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, N'($urandom));
        applyStimulus(1'b0, 1'b0, N'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
